// File: rtl/cpu_datapath.sv
// 32-bit single-bus datapath: R0-R15, HI, LO, PC, IR, MAR, MDR, Y, 64-bit Z.
// Register transfers and ALU operations are driven by one-hot strobes.
module cpu_datapath (
    input  logic        clock,
    input  logic        clear,
    input  logic        R0in,  R1in,  R2in,  R3in,  R4in,  R5in,  R6in,  R7in,
    input  logic        R8in,  R9in,  R10in, R11in, R12in, R13in, R14in, R15in,
    input  logic        HIin, LOin, PCin, IRin, Yin, Zin, MARin, MDRin,
    input  logic        R0out,  R1out,  R2out,  R3out,  R4out,  R5out,  R6out,  R7out,
    input  logic        R8out,  R9out,  R10out, R11out, R12out, R13out, R14out, R15out,
    input  logic        HIout, LOout, Zhighout, Zlowout, PCout, MDRout, InPortout, Cout,
    input  logic        IncPC, ADD, SUB, AND, OR, SHR, SHRA, SHL, ROR, ROL, NEG, NOT, MUL, DIV,
    input  logic        Read,
    input  logic [31:0] Mdatain,
    output logic [31:0] R0,  R1,  R2,  R3,  R4,  R5,  R6,  R7,
    output logic [31:0] R8,  R9,  R10, R11, R12, R13, R14, R15,
    output logic [31:0] HI, LO, PC_out, IR, MAR, Y,
    output logic [63:0] Z,
    output logic [31:0] BusMuxOut_signal
);
    localparam int unsigned DW   = 32;
    localparam int unsigned ZW   = 64;
    localparam int unsigned NREG = 16;

    logic [DW-1:0]   gpr [NREG];
    logic [DW-1:0]   mdr;
    logic [DW-1:0]   bus;
    logic [ZW-1:0]   alu_res;
    logic [NREG-1:0] r_in;
    logic [NREG-1:0] r_out;

    assign r_in  = {R15in, R14in, R13in, R12in, R11in, R10in, R9in, R8in,
                    R7in,  R6in,  R5in,  R4in,  R3in,  R2in,  R1in, R0in};
    assign r_out = {R15out, R14out, R13out, R12out, R11out, R10out, R9out, R8out,
                    R7out,  R6out,  R5out,  R4out,  R3out,  R2out,  R1out, R0out};

    assign R0  = gpr[0];  assign R1  = gpr[1];  assign R2  = gpr[2];  assign R3  = gpr[3];
    assign R4  = gpr[4];  assign R5  = gpr[5];  assign R6  = gpr[6];  assign R7  = gpr[7];
    assign R8  = gpr[8];  assign R9  = gpr[9];  assign R10 = gpr[10]; assign R11 = gpr[11];
    assign R12 = gpr[12]; assign R13 = gpr[13]; assign R14 = gpr[14]; assign R15 = gpr[15];

    assign BusMuxOut_signal = bus;

    // Bus mux: lowest priority source first, so higher-priority selects overwrite.
    always_comb begin
        bus = '0;
        if (Cout)      bus = {{13{IR[18]}}, IR[18:0]};
        if (InPortout) bus = '0;
        if (MDRout)    bus = mdr;
        if (PCout)     bus = PC_out;
        if (Zlowout)   bus = Z[31:0];
        if (Zhighout)  bus = Z[63:32];
        if (LOout)     bus = LO;
        if (HIout)     bus = HI;
        for (int i = int'(NREG) - 1; i >= 0; i--) begin
            if (r_out[4'(i)]) bus = gpr[4'(i)];
        end
    end

    // ALU: A = Y, B = bus; operations checked in fixed priority order.
    logic signed [ZW-1:0] a_ext, b_ext;
    logic        [ZW-1:0] prod;
    logic        [DW-1:0] quo, rem, ror_w, rol_w;
    logic        [4:0]    sh;

    always_comb begin
        sh    = bus[4:0];
        a_ext = {{32{Y[31]}}, Y};
        b_ext = {{32{bus[31]}}, bus};
        prod  = a_ext * b_ext;
        // 64-bit signed divide keeps the -2^31 / -1 case representable
        quo   = (bus == '0) ? '0 : 32'(a_ext / b_ext);
        rem   = (bus == '0) ? '0 : 32'(a_ext % b_ext);
        ror_w = 32'({Y, Y} >> sh);
        rol_w = 32'(({Y, Y} << sh) >> 32);
        alu_res = '0;
        if      (IncPC) alu_res = {32'd0, bus + 32'd1};
        else if (ADD)   alu_res = {32'd0, Y + bus};
        else if (SUB)   alu_res = {32'd0, Y - bus};
        else if (AND)   alu_res = {32'd0, Y & bus};
        else if (OR)    alu_res = {32'd0, Y | bus};
        else if (SHR)   alu_res = {32'd0, Y >> sh};
        else if (SHRA)  alu_res = {32'd0, 32'($signed(Y) >>> sh)};
        else if (SHL)   alu_res = {32'd0, Y << sh};
        else if (ROR)   alu_res = {32'd0, ror_w};
        else if (ROL)   alu_res = {32'd0, rol_w};
        else if (NEG)   alu_res = {32'd0, 32'd0 - bus};
        else if (NOT)   alu_res = {32'd0, ~bus};
        else if (MUL)   alu_res = prod;
        else if (DIV)   alu_res = {rem, quo};
    end

    // Register file and special registers; clear overrides every enable.
    always_ff @(posedge clock or negedge clear) begin
        if (!clear) begin
            for (int i = 0; i < int'(NREG); i++) gpr[4'(i)] <= '0;
            HI     <= '0;
            LO     <= '0;
            PC_out <= '0;
            IR     <= '0;
            MAR    <= '0;
            mdr    <= '0;
            Y      <= '0;
            Z      <= '0;
        end else begin
            for (int i = 0; i < int'(NREG); i++) begin
                if (r_in[4'(i)]) gpr[4'(i)] <= bus;
            end
            if (HIin)  HI     <= bus;
            if (LOin)  LO     <= bus;
            if (PCin)  PC_out <= bus;
            if (IRin)  IR     <= bus;
            if (MARin) MAR    <= bus;
            if (Yin)   Y      <= bus;
            if (MDRin) mdr    <= Read ? Mdatain : bus;
            if (Zin)   Z      <= alu_res;
        end
    end
endmodule

// File: tb/tb_cpu_datapath.sv
// Scoreboard bench for cpu_datapath: stimulus queues expected values,
// a monitor compares them once their cycle is due.
module tb_cpu_datapath;
    localparam int ID_HI = 16, ID_LO = 17, ID_PC = 18, ID_IR = 19, ID_MAR = 20;
    localparam int ID_Y = 21, ID_Z = 22, ID_BUS = 23;
    localparam int ID_MDR = 24, ID_ZH = 25, ID_ZL = 26, ID_INP = 27, ID_C = 28;
    localparam int OP_INC = 0, OP_ADD = 1, OP_SUB = 2, OP_AND = 3, OP_OR = 4, OP_SHR = 5;
    localparam int OP_SHRA = 6, OP_SHL = 7, OP_ROR = 8, OP_ROL = 9, OP_NEG = 10;
    localparam int OP_NOT = 11, OP_MUL = 12, OP_DIV = 13;

    logic        clock, clear;
    logic [15:0] rin, rout;
    logic        hiin, loin, pcin, irin, yin, zin, marin, mdrin;
    logic        hiout, loout, zhout, zlout, pcout, mdrout, inpout, cout;
    logic [13:0] op;
    logic        rd;
    logic [31:0] mdatain;
    logic [31:0] r_o [16];
    logic [31:0] hi_o, lo_o, pc_o, ir_o, mar_o, y_o, bus_o;
    logic [63:0] z_o;

    typedef struct {
        string       name;
        int          sel;
        logic [63:0] exp;
        int          due;
    } exp_t;

    exp_t sb[$];
    int   cyc = 0;
    int   n_checks = 0;
    int   n_fail = 0;

    cpu_datapath dut (
        .clock(clock), .clear(clear),
        .R0in(rin[0]), .R1in(rin[1]), .R2in(rin[2]), .R3in(rin[3]),
        .R4in(rin[4]), .R5in(rin[5]), .R6in(rin[6]), .R7in(rin[7]),
        .R8in(rin[8]), .R9in(rin[9]), .R10in(rin[10]), .R11in(rin[11]),
        .R12in(rin[12]), .R13in(rin[13]), .R14in(rin[14]), .R15in(rin[15]),
        .HIin(hiin), .LOin(loin), .PCin(pcin), .IRin(irin), .Yin(yin), .Zin(zin),
        .MARin(marin), .MDRin(mdrin),
        .R0out(rout[0]), .R1out(rout[1]), .R2out(rout[2]), .R3out(rout[3]),
        .R4out(rout[4]), .R5out(rout[5]), .R6out(rout[6]), .R7out(rout[7]),
        .R8out(rout[8]), .R9out(rout[9]), .R10out(rout[10]), .R11out(rout[11]),
        .R12out(rout[12]), .R13out(rout[13]), .R14out(rout[14]), .R15out(rout[15]),
        .HIout(hiout), .LOout(loout), .Zhighout(zhout), .Zlowout(zlout), .PCout(pcout),
        .MDRout(mdrout), .InPortout(inpout), .Cout(cout),
        .IncPC(op[OP_INC]), .ADD(op[OP_ADD]), .SUB(op[OP_SUB]), .AND(op[OP_AND]),
        .OR(op[OP_OR]), .SHR(op[OP_SHR]), .SHRA(op[OP_SHRA]), .SHL(op[OP_SHL]),
        .ROR(op[OP_ROR]), .ROL(op[OP_ROL]), .NEG(op[OP_NEG]), .NOT(op[OP_NOT]),
        .MUL(op[OP_MUL]), .DIV(op[OP_DIV]),
        .Read(rd), .Mdatain(mdatain),
        .R0(r_o[0]), .R1(r_o[1]), .R2(r_o[2]), .R3(r_o[3]),
        .R4(r_o[4]), .R5(r_o[5]), .R6(r_o[6]), .R7(r_o[7]),
        .R8(r_o[8]), .R9(r_o[9]), .R10(r_o[10]), .R11(r_o[11]),
        .R12(r_o[12]), .R13(r_o[13]), .R14(r_o[14]), .R15(r_o[15]),
        .HI(hi_o), .LO(lo_o), .PC_out(pc_o), .IR(ir_o), .MAR(mar_o), .Y(y_o),
        .Z(z_o), .BusMuxOut_signal(bus_o)
    );

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    always @(posedge clock) cyc++;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic logic [63:0] probe(input int sel);
        logic [3:0] idx;
        idx = sel[3:0];
        case (sel)
            ID_HI:   return {32'd0, hi_o};
            ID_LO:   return {32'd0, lo_o};
            ID_PC:   return {32'd0, pc_o};
            ID_IR:   return {32'd0, ir_o};
            ID_MAR:  return {32'd0, mar_o};
            ID_Y:    return {32'd0, y_o};
            ID_Z:    return z_o;
            ID_BUS:  return {32'd0, bus_o};
            default: return {32'd0, r_o[idx]};
        endcase
    endfunction

    // Monitor: compare every queued expectation whose cycle has arrived.
    initial begin
        int i;
        logic [63:0] act;
        forever begin
            @(negedge clock);
            #2;
            i = 0;
            while (i < sb.size()) begin
                if (sb[i].due <= cyc) begin
                    act = probe(sb[i].sel);
                    n_checks++;
                    if (act !== sb[i].exp) begin
                        n_fail++;
                        $display("FAIL %s: got %h, expected %h", sb[i].name, act, sb[i].exp);
                    end
                    sb.delete(i);
                end else begin
                    i++;
                end
            end
        end
    end

    task automatic idle();
        rin = '0; rout = '0; op = '0;
        {hiin, loin, pcin, irin, yin, zin, marin, mdrin} = '0;
        {hiout, loout, zhout, zlout, pcout, mdrout, inpout, cout} = '0;
        rd = 1'b0;
        mdatain = '0;
    endtask

    task automatic step();
        @(negedge clock);
        #1;
        idle();
    endtask

    task automatic set_in(input int id);
        case (id)
            ID_HI:   hiin  = 1'b1;
            ID_LO:   loin  = 1'b1;
            ID_PC:   pcin  = 1'b1;
            ID_IR:   irin  = 1'b1;
            ID_MAR:  marin = 1'b1;
            ID_Y:    yin   = 1'b1;
            default: rin[id[3:0]] = 1'b1;
        endcase
    endtask

    task automatic set_out(input int id);
        case (id)
            ID_HI:   hiout  = 1'b1;
            ID_LO:   loout  = 1'b1;
            ID_PC:   pcout  = 1'b1;
            ID_MDR:  mdrout = 1'b1;
            ID_ZH:   zhout  = 1'b1;
            ID_ZL:   zlout  = 1'b1;
            ID_INP:  inpout = 1'b1;
            ID_C:    cout   = 1'b1;
            default: rout[id[3:0]] = 1'b1;
        endcase
    endtask

    task automatic expect_now(input string n, input int sel, input logic [63:0] v);
        sb.push_back('{n, sel, v, cyc});
    endtask

    task automatic expect_next(input string n, input int sel, input logic [63:0] v);
        sb.push_back('{n, sel, v, cyc + 1});
    endtask

    task automatic load_mdr(input logic [31:0] v);
        step();
        rd = 1'b1; mdrin = 1'b1; mdatain = v;
    endtask

    task automatic load_reg(input int id, input logic [31:0] v);
        load_mdr(v);
        step();
        mdrout = 1'b1;
        set_in(id);
    endtask

    // Y <- a, MDR <- b, then drive b on the bus with the given op mask into Z.
    task automatic alu_test(input string n, input logic [13:0] m, input logic [31:0] a,
                            input logic [31:0] b, input logic [63:0] exp);
        load_mdr(a);
        step();
        mdrout = 1'b1; yin = 1'b1;
        rd = 1'b1; mdrin = 1'b1; mdatain = b;
        step();
        mdrout = 1'b1; op = m; zin = 1'b1;
        expect_next(n, ID_Z, exp);
    endtask

    function automatic logic [13:0] opm(input int k);
        logic [13:0] m;
        m = '0;
        m[k[3:0]] = 1'b1;
        return m;
    endfunction

    initial begin
        idle();
        clear = 1'b0;
        rin[5] = 1'b1; rd = 1'b1; mdrin = 1'b1; mdatain = 32'hFFFF_FFFF;
        @(negedge clock);
        #1;
        n_checks++;
        if (r_o[5] !== 32'd0) begin
            n_fail++;
            $display("FAIL direct_reset_r5: got %h, expected 0", r_o[5]);
        end
        n_checks++;
        if (z_o !== 64'd0) begin
            n_fail++;
            $display("FAIL direct_reset_z: got %h, expected 0", z_o);
        end
        n_checks++;
        if (mar_o !== 32'd0) begin
            n_fail++;
            $display("FAIL direct_reset_mar: got %h, expected 0", mar_o);
        end
        for (int k = 0; k <= ID_Z; k++) expect_now($sformatf("reset_id%0d", k), k, 64'd0);
        rin = '0; rd = 1'b0; mdrin = 1'b0;
        #1;
        n_checks++;
        if (bus_o !== 32'd0) begin
            n_fail++;
            $display("FAIL direct_reset_bus: got %h, expected 0", bus_o);
        end
        expect_now("reset_bus", ID_BUS, 64'd0);
        step();
        clear = 1'b1;

        // NEG sequence
        load_mdr(32'h0000_000A);
        step(); set_out(ID_MDR); set_in(7);
        expect_now("neg_bus_mdr", ID_BUS, 64'h0000_000A);
        expect_next("neg_r7", 7, 64'h0000_000A);
        step(); set_out(ID_PC); set_in(ID_MAR); op = opm(OP_INC); zin = 1'b1;
        expect_next("neg_incpc_z", ID_Z, 64'd1);
        expect_next("neg_mar", ID_MAR, 64'd0);
        step(); set_out(ID_ZL); set_in(ID_PC); rd = 1'b1; mdrin = 1'b1; mdatain = 32'h0007_FFFF;
        expect_next("neg_pc", ID_PC, 64'd1);
        step(); set_out(ID_MDR); set_in(ID_IR);
        expect_next("neg_ir", ID_IR, 64'h0007_FFFF);
        step(); set_out(7); op = opm(OP_NEG); zin = 1'b1;
        expect_next("neg_z", ID_Z, 64'h0000_0000_FFFF_FFF6);
        step(); set_out(ID_ZL); set_in(4);
        expect_next("neg_r4", 4, 64'h0000_0000_FFFF_FFF6);

        // Cout sign extension and InPort priority
        step(); set_out(ID_C);
        expect_now("cout_sext", ID_BUS, 64'h0000_0000_FFFF_FFFF);
        step(); set_out(ID_C); set_out(ID_INP);
        expect_now("inport_over_c", ID_BUS, 64'd0);

        // Bus priority and self-transfer
        load_reg(1, 32'h1111_1111);
        load_reg(2, 32'h2222_2222);
        load_reg(ID_HI, 32'hAAAA_0000);
        load_reg(ID_LO, 32'h0000_BBBB);
        step(); set_out(1); set_out(2);
        expect_now("prio_r1_r2", ID_BUS, 64'h1111_1111);
        step(); set_out(ID_HI); set_out(ID_LO);
        expect_now("prio_hi_lo", ID_BUS, 64'hAAAA_0000);
        step(); set_out(2); set_out(ID_HI);
        expect_now("prio_r2_hi", ID_BUS, 64'h2222_2222);
        step(); set_out(ID_PC); set_out(ID_MDR);
        expect_now("prio_pc_mdr", ID_BUS, 64'd1);
        step(); set_out(1); set_in(1);
        expect_next("self_r1", 1, 64'h1111_1111);

        // ALU
        alu_test("add_ovf", opm(OP_ADD), 32'h7FFF_FFFF, 32'd1, 64'h0000_0000_8000_0000);
        expect_next("y_load", ID_Y, 64'h7FFF_FFFF);
        alu_test("sub_neg", opm(OP_SUB), 32'd3, 32'd5, 64'h0000_0000_FFFF_FFFE);
        alu_test("and", opm(OP_AND), 32'hF0F0_F0F0, 32'hFF00_FF00, 64'h0000_0000_F000_F000);
        alu_test("or", opm(OP_OR), 32'hF0F0_F0F0, 32'hFF00_FF00, 64'h0000_0000_FFF0_FFF0);
        alu_test("not", opm(OP_NOT), 32'd0, 32'h0000_FFFF, 64'h0000_0000_FFFF_0000);
        alu_test("mul_neg", opm(OP_MUL), 32'hFFFF_FFFA, 32'd4, 64'hFFFF_FFFF_FFFF_FFE8);
        step(); set_out(ID_ZH); set_out(ID_ZL);
        expect_now("prio_zh_zl", ID_BUS, 64'h0000_0000_FFFF_FFFF);
        alu_test("div_neg", opm(OP_DIV), 32'hFFFF_FFF9, 32'd2, 64'hFFFF_FFFF_FFFF_FFFD);
        alu_test("div_negdiv", opm(OP_DIV), 32'd7, 32'hFFFF_FFFE, 64'h0000_0001_FFFF_FFFD);
        alu_test("div_min", opm(OP_DIV), 32'h8000_0000, 32'hFFFF_FFFF, 64'h0000_0000_8000_0000);
        alu_test("div_zero", opm(OP_DIV), 32'd7, 32'd0, 64'd0);
        alu_test("shr", opm(OP_SHR), 32'h8000_0001, 32'd1, 64'h0000_0000_4000_0000);
        alu_test("shra", opm(OP_SHRA), 32'h8000_0001, 32'd1, 64'h0000_0000_C000_0000);
        alu_test("shl", opm(OP_SHL), 32'h8000_0001, 32'd1, 64'h0000_0000_0000_0002);
        alu_test("ror", opm(OP_ROR), 32'h8000_0001, 32'd1, 64'h0000_0000_C000_0000);
        alu_test("rol", opm(OP_ROL), 32'h8000_0001, 32'd1, 64'h0000_0000_0000_0003);
        alu_test("shl_amt5", opm(OP_SHL), 32'd1, 32'h0000_0021, 64'h0000_0000_0000_0002);
        alu_test("op_prio", opm(OP_ADD) | opm(OP_SUB), 32'd3, 32'd5, 64'd8);
        alu_test("no_op", 14'd0, 32'd3, 32'd5, 64'd0);
        alu_test("mul_big", opm(OP_MUL), 32'h0001_0000, 32'h0001_0000, 64'h0000_0001_0000_0000);

        // Asynchronous clear mid-sequence
        load_reg(3, 32'hDEAD_BEEF);
        step(); set_out(3); set_in(6); clear = 1'b0;
        expect_now("clr_r3", 3, 64'd0);
        expect_now("clr_z", ID_Z, 64'd0);
        expect_now("clr_y", ID_Y, 64'd0);
        expect_now("clr_r1", 1, 64'd0);
        expect_next("clr_r6", 6, 64'd0);
        step(); clear = 1'b1;
        step(); set_out(ID_MDR); set_in(8);
        expect_next("clr_mdr", 8, 64'd0);

        step();
        for (int k = 0; k < 20 && sb.size() != 0; k++) @(negedge clock);
        #3;
        n_checks++;
        if (r_o[3] !== 32'd0) begin
            n_fail++;
            $display("FAIL direct_clr_r3: got %h, expected 0", r_o[3]);
        end
        n_checks++;
        if (r_o[6] !== 32'd0) begin
            n_fail++;
            $display("FAIL direct_clr_r6: got %h, expected 0", r_o[6]);
        end
        n_checks++;
        if (r_o[8] !== 32'd0) begin
            n_fail++;
            $display("FAIL direct_clr_r8: got %h, expected 0", r_o[8]);
        end
        while (sb.size() != 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL %s: got no comparison, expected %h", sb[0].name, sb[0].exp);
            sb.delete(0);
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
